// File: rtl/put_in_order_rob_if.sv
// Handshake bundle for put_in_order_rob: per-channel upstream results in, one ordered stream out.
interface put_in_order_rob_if #(
  parameter int width    = 16,
  parameter int n_inputs = 4
);
  logic [n_inputs-1:0]            up_vlds;
  logic [n_inputs-1:0][width-1:0] up_data;
  logic [n_inputs-1:0]            up_rdys;
  logic                           down_vld;
  logic                           down_rdy;
  logic [width-1:0]               down_data;
  logic                           overflow;

  modport master (
    output up_vlds, up_data, down_rdy,
    input  up_rdys, down_vld, down_data, overflow
  );

  modport slave (
    input  up_vlds, up_data, down_rdy,
    output up_rdys, down_vld, down_data, overflow
  );
endinterface

// File: rtl/put_in_order_rob.sv
// Reorder buffer: one FIFO per channel, drained strictly round-robin starting at channel 0.
// Optional zero-latency bypass of an empty head channel is enabled by macro PUT_IN_ORDER_BYPASS_EN.
module put_in_order_rob #(
  parameter int width    = 16,
  parameter int n_inputs = 4,
  parameter int depth    = 4
) (
  input  logic              clk,
  input  logic              rst,
  put_in_order_rob_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(n_inputs);
  localparam logic [CW-1:0] LastCh = CW'(n_inputs - 1);

  logic [width-1:0]    mem_q    [n_inputs][depth];
  logic [AW:0]         wr_ptr_q [n_inputs];
  logic [AW:0]         wr_ptr_d [n_inputs];
  logic [AW:0]         rd_ptr_q [n_inputs];
  logic [AW:0]         rd_ptr_d [n_inputs];
  logic [CW-1:0]       rd_ch_q, rd_ch_d;
  logic                overflow_q, overflow_d;

  logic [n_inputs-1:0] empty, full, push, pop_ch;
  logic [width-1:0]    head_data, out_data;
  logic                head_empty, bypass, out_vld, xfer;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int i = 0; i < n_inputs; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  assign head_empty = empty[rd_ch_q];
  assign head_data  = mem_q[rd_ch_q][rd_ptr_q[rd_ch_q][AW-1:0]];

`ifdef PUT_IN_ORDER_BYPASS_EN
  assign bypass   = head_empty && bus.up_vlds[rd_ch_q];
  assign out_data = bypass ? bus.up_data[rd_ch_q] : head_data;
`else
  assign bypass   = 1'b0;
  assign out_data = head_data;
`endif

  assign out_vld = rst && (!head_empty || bypass);
  assign xfer    = out_vld && bus.down_rdy;

  // A word is dropped only when its FIFO is full and not being drained this cycle.
  always_comb begin
    overflow_d = overflow_q;
    rd_ch_d    = rd_ch_q;
    if (xfer) begin
      rd_ch_d = (rd_ch_q == LastCh) ? '0 : rd_ch_q + 1'b1;
    end
    for (int i = 0; i < n_inputs; i++) begin
      pop_ch[i] = xfer && !bypass && (rd_ch_q == CW'(i));
      push[i]   = bus.up_vlds[i] && !(full[i] && !pop_ch[i]) &&
                  !(bypass && xfer && (rd_ch_q == CW'(i)));
      if (bus.up_vlds[i] && full[i] && !pop_ch[i]) begin
        overflow_d = 1'b1;
      end
      wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop_ch[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ch_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < n_inputs; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      rd_ch_q    <= rd_ch_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < n_inputs; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < n_inputs; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.up_data[i];
      end
    end
  end

  assign bus.up_rdys   = {n_inputs{rst}} & ~full;
  assign bus.down_vld  = out_vld;
  assign bus.down_data = out_vld ? out_data : '0;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_put_in_order_rob.sv
// Directed self-checking bench for put_in_order_rob (width=16, n_inputs=4, depth=4).
// Ordered-stream checks compare each accepted word against an incrementing expected counter.
module tb_put_in_order_rob;
  logic clock;
  logic rstN;
  int   assertCount;
  int   failCount;
  int   expWord;
  bit   scoreOn;
  logic lastVld;
  logic [3:0][15:0] dataVec;
  int   base;
  int   lat [4];
  logic [3:0] vlds;

  put_in_order_rob_if #(.width(16), .n_inputs(4)) bus ();

  put_in_order_rob #(.width(16), .n_inputs(4), .depth(4)) dut (
    .clk (clock),
    .rst (rstN),
    .bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock of stimulus; accepted words are scored when scoring is enabled.
  task automatic applyStimulus(input logic [3:0] v, input logic rdy);
    bus.up_vlds  = v;
    bus.up_data  = dataVec;
    bus.down_rdy = rdy;
    #1;
    lastVld = bus.down_vld;
    if (scoreOn && bus.down_vld && rdy) begin
      checkOutput("order", 32'(bus.down_data), 32'(expWord));
      expWord++;
    end
    tick();
  endtask

  task automatic doReset();
    rstN         = 1'b0;
    bus.up_vlds  = '0;
    bus.down_rdy = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    expWord     = 0;
    scoreOn     = 1'b0;
    dataVec     = '0;
    rstN        = 1'b0;
    bus.up_vlds  = 4'b0001;
    bus.up_data  = '0;
    bus.up_data[0] = 16'h1111;
    bus.down_rdy = 1'b0;
    #2;
    checkOutput("rst_vld",      32'(bus.down_vld),  32'd0);
    checkOutput("rst_data",     32'(bus.down_data), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow),  32'd0);
    checkOutput("rst_rdys",     32'(bus.up_rdys),   32'd0);
    tick();
    tick();
    rstN        = 1'b1;
    bus.up_vlds = '0;
    #1;
    checkOutput("post_rst_rdys", 32'(bus.up_rdys),  32'hF);
    checkOutput("rst_write_dropped", 32'(bus.down_vld), 32'd0);

    // Latency of a single word into an empty buffer.
    dataVec[0]   = 16'h00A5;
    bus.up_data  = dataVec;
    bus.up_vlds  = 4'b0001;
    bus.down_rdy = 1'b1;
    #1;
`ifdef PUT_IN_ORDER_BYPASS_EN
    checkOutput("lat_vld_c0",  32'(bus.down_vld),  32'd1);
    checkOutput("lat_data_c0", 32'(bus.down_data), 32'h00A5);
`else
    checkOutput("lat_vld_c0",  32'(bus.down_vld),  32'd0);
    checkOutput("lat_data_c0", 32'(bus.down_data), 32'd0);
`endif
    tick();
    bus.up_vlds = '0;
    #1;
`ifdef PUT_IN_ORDER_BYPASS_EN
    checkOutput("lat_vld_c1",  32'(bus.down_vld),  32'd0);
`else
    checkOutput("lat_vld_c1",  32'(bus.down_vld),  32'd1);
    checkOutput("lat_data_c1", 32'(bus.down_data), 32'h00A5);
`endif
    tick();
    doReset();

    // Sweep every combination of per-channel return latency 0..3.
    scoreOn = 1'b1;
    for (int combo = 0; combo < 256; combo++) begin
      base = expWord;
      for (int ch = 0; ch < 4; ch++) begin
        lat[ch]     = (combo >> (2 * ch)) & 3;
        dataVec[ch] = 16'(base + ch);
      end
      for (int c = 0; c < 16; c++) begin
        for (int ch = 0; ch < 4; ch++) vlds[ch] = (c == ch + lat[ch]);
        applyStimulus(vlds, 1'b1);
      end
      checkOutput("sweep_count", 32'(expWord - base), 32'd4);
    end

    // Channel 2 returns early; its word must wait for channel 1.
    base = expWord;
    for (int ch = 0; ch < 4; ch++) dataVec[ch] = 16'(base + ch);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("held_gap", 32'(lastVld), 32'd0);
    applyStimulus(4'b1010, 1'b1);
    repeat (6) applyStimulus(4'b0000, 1'b1);
    checkOutput("reorder_count", 32'(expWord - base), 32'd4);

    // Reset mid-stream with three words buffered on channel 0.
    scoreOn = 1'b0;
    doReset();
    for (int k = 0; k < 3; k++) begin
      dataVec[0] = 16'(16'h0200 + k);
      applyStimulus(4'b0001, 1'b0);
    end
    checkOutput("pre_reset_vld", 32'(bus.down_vld), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_vld",  32'(bus.down_vld),  32'd0);
    checkOutput("midrst_data", 32'(bus.down_data), 32'd0);
    checkOutput("midrst_rdys", 32'(bus.up_rdys),   32'd0);
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("midrst_release_rdys", 32'(bus.up_rdys), 32'hF);
    scoreOn = 1'b1;
    base = expWord;
    dataVec[1] = 16'(base + 1);
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wait_ch0", 32'(lastVld), 32'd0);
    dataVec[0] = 16'(base);
    applyStimulus(4'b0001, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1);
    checkOutput("post_reset_count", 32'(expWord - base), 32'd2);

    // Fill channel 0 with the output stalled, then overflow it.
    scoreOn = 1'b0;
    doReset();
    for (int k = 0; k < 4; k++) begin
      dataVec[0] = 16'(16'h0100 + k);
      applyStimulus(4'b0001, 1'b0);
    end
    checkOutput("full_rdys",     32'(bus.up_rdys),   32'hE);
    checkOutput("full_no_ovf",   32'(bus.overflow),  32'd0);
    checkOutput("full_head",     32'(bus.down_data), 32'h0100);
    dataVec[0] = 16'h0104;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("overflow_set",  32'(bus.overflow),  32'd1);
    repeat (5) applyStimulus(4'b0000, 1'b0);
    checkOutput("held_vld",        32'(bus.down_vld),  32'd1);
    checkOutput("held_data",       32'(bus.down_data), 32'h0100);
    checkOutput("overflow_sticky", 32'(bus.overflow),  32'd1);

    // Write into a full FIFO that is popped in the same cycle.
    doReset();
    for (int k = 0; k < 4; k++) begin
      dataVec[0] = 16'(16'h0300 + k);
      applyStimulus(4'b0001, 1'b0);
    end
    dataVec[0]   = 16'h0305;
    bus.up_data  = dataVec;
    bus.up_vlds  = 4'b0001;
    bus.down_rdy = 1'b1;
    #1;
    checkOutput("simul_head", 32'(bus.down_data), 32'h0300);
    tick();
    bus.up_vlds  = '0;
    bus.down_rdy = 1'b0;
    #1;
    checkOutput("simul_no_ovf",   32'(bus.overflow), 32'd0);
    checkOutput("simul_retained", 32'(bus.up_rdys),  32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
